// File: rtl/cpu_fetch_pkg.sv
// rtl/cpu_fetch_pkg.sv - shared definitions for the instruction-fetch stage
// Purpose: word width, default reset PC / PC step and the fetch FSM state encoding.
package cpu_fetch_pkg;

  localparam int WORD_W = 16;

  localparam logic [WORD_W-1:0] DEFAULT_RESET_PC = 16'h0000;
  localparam logic [WORD_W-1:0] DEFAULT_PC_STEP  = 16'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/pc_fetch_unit_pcadder.sv
// rtl/pc_fetch_unit_pcadder.sv - PC adder used for the sequential next PC
// Purpose: unsigned WORD_W-bit add with carry out (sum wraps modulo 2^WORD_W).
// Ports:
//   A        in  WORD_W  current PC
//   B        in  WORD_W  increment
//   Sum      out WORD_W  A+B modulo 2^WORD_W
//   CarryOut out 1       carry out of the MSB
module PCadder
  import cpu_fetch_pkg::*;
(
  input  logic [WORD_W-1:0] A,
  input  logic [WORD_W-1:0] B,
  output logic [WORD_W-1:0] Sum,
  output logic              CarryOut
);

  assign {CarryOut, Sum} = {1'b0, A} + {1'b0, B};

endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - PC register and instruction-fetch stage
// Purpose: holds the PC, issues fetches to instruction memory, delivers
// {instruction, PC} to decode over valid/ready, applies branch/jump redirects
// and drops responses made stale by a redirect.
// Ports:
//   Clock        in  1   rising-edge clock
//   ResetN       in  1   asynchronous active-low reset
//   Branch       in  1   redirect to BranchTarget
//   BranchTarget in  16  branch destination
//   Jump         in  1   redirect to JumpTarget (wins over Branch)
//   JumpTarget   in  16  jump destination
//   IMemReq      out 1   fetch request valid
//   IMemAddr     out 16  fetch address (0 when no request)
//   IMemGnt      in  1   memory accepts the request
//   IMemRvalid   in  1   response valid
//   IMemRdata    in  16  fetched instruction word
//   InstrValid   out 1   Instr/InstrPC valid toward decode
//   InstrReady   in  1   decode consumes Instr
//   Instr        out 16  instruction word
//   InstrPC      out 16  address the instruction was fetched from
//   PCOverflow   out 1   sticky: sequential increment wrapped past the top
module pc_fetch_unit
  import cpu_fetch_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [WORD_W-1:0] PC_STEP  = DEFAULT_PC_STEP
) (
  input  logic              Clock,
  input  logic              ResetN,
  input  logic              Branch,
  input  logic [WORD_W-1:0] BranchTarget,
  input  logic              Jump,
  input  logic [WORD_W-1:0] JumpTarget,
  output logic              IMemReq,
  output logic [WORD_W-1:0] IMemAddr,
  input  logic              IMemGnt,
  input  logic              IMemRvalid,
  input  logic [WORD_W-1:0] IMemRdata,
  output logic              InstrValid,
  input  logic              InstrReady,
  output logic [WORD_W-1:0] Instr,
  output logic [WORD_W-1:0] InstrPC,
  output logic              PCOverflow
);

  fetch_state_t      state_q, state_d;
  logic [WORD_W-1:0] pc_q, pc_d;
  logic [WORD_W-1:0] req_pc_q, req_pc_d;
  logic              discard_q, discard_d;
  logic [WORD_W-1:0] instr_q, instr_d;
  logic [WORD_W-1:0] instr_pc_q, instr_pc_d;
  logic              valid_q, valid_d;
  logic [WORD_W-1:0] skid_data_q, skid_data_d;
  logic [WORD_W-1:0] skid_pc_q, skid_pc_d;
  logic              ovf_q, ovf_d;

  logic [WORD_W-1:0] pc_next;
  logic              pc_carry;
  logic              redirect;
  logic [WORD_W-1:0] target;
  logic              output_free;

  PCadder u_pcadder (
    .A        (pc_q),
    .B        (PC_STEP),
    .Sum      (pc_next),
    .CarryOut (pc_carry)
  );

  assign redirect    = Jump | Branch;
  assign target      = (Jump ? JumpTarget : BranchTarget) & ~{{(WORD_W-1){1'b0}}, 1'b1};
  assign output_free = ~valid_q | InstrReady;

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      pc_q        <= RESET_PC;
      req_pc_q    <= '0;
      discard_q   <= 1'b0;
      instr_q     <= '0;
      instr_pc_q  <= '0;
      valid_q     <= 1'b0;
      skid_data_q <= '0;
      skid_pc_q   <= '0;
      ovf_q       <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      discard_q   <= discard_d;
      instr_q     <= instr_d;
      instr_pc_q  <= instr_pc_d;
      valid_q     <= valid_d;
      skid_data_q <= skid_data_d;
      skid_pc_q   <= skid_pc_d;
      ovf_q       <= ovf_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    discard_d   = discard_q;
    instr_d     = instr_q;
    instr_pc_d  = instr_pc_q;
    valid_d     = valid_q & ~InstrReady;
    skid_data_d = skid_data_q;
    skid_pc_d   = skid_pc_q;
    ovf_d       = ovf_q;

    IMemReq  = (state_q == ST_FETCH);
    IMemAddr = (state_q == ST_FETCH) ? pc_q : '0;

    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (IMemGnt) begin
          req_pc_d = pc_q;
          pc_d     = pc_next;
          ovf_d    = ovf_q | pc_carry;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (IMemRvalid) begin
          if (discard_q) begin
            discard_d = 1'b0;
            state_d   = ST_FETCH;
          end else if (output_free) begin
            instr_d    = IMemRdata;
            instr_pc_d = req_pc_q;
            valid_d    = 1'b1;
            state_d    = ST_FETCH;
          end else begin
            skid_data_d = IMemRdata;
            skid_pc_d   = req_pc_q;
            state_d     = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        // Output is necessarily occupied here, so InstrReady means a transfer.
        if (InstrReady) begin
          instr_d    = skid_data_q;
          instr_pc_d = skid_pc_q;
          valid_d    = 1'b1;
          state_d    = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (redirect) begin
      pc_d        = target;
      ovf_d       = ovf_q;
      valid_d     = 1'b0;
      skid_data_d = '0;
      skid_pc_d   = '0;
      // A fetch still outstanding after this edge must be dropped when it returns.
      // A response arriving in this very cycle already closes the old fetch.
      if ((state_q == ST_WAIT && !IMemRvalid) || (state_q == ST_FETCH && IMemGnt)) begin
        discard_d = 1'b1;
        state_d   = ST_WAIT;
      end else begin
        discard_d = 1'b0;
        state_d   = ST_FETCH;
      end
    end
  end

  assign InstrValid = valid_q;
  assign Instr      = instr_q;
  assign InstrPC    = instr_pc_q;
  assign PCOverflow = ovf_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - directed self-checking bench for pc_fetch_unit
module tb_pc_fetch_unit;

  logic        Clock;
  logic        ResetN;
  logic        Branch, Jump;
  logic [15:0] BranchTarget, JumpTarget;
  logic        IMemReq, IMemGnt, IMemRvalid;
  logic [15:0] IMemAddr, IMemRdata;
  logic        InstrValid, InstrReady, PCOverflow;
  logic [15:0] Instr, InstrPC;

  logic        b_rstn, b_rvalid;
  logic [15:0] b_rdata;
  logic        b_req, b_valid, b_ovf;
  logic [15:0] b_addr, b_instr, b_instr_pc;

  int errors = 0;
  int checks = 0;

  pc_fetch_unit dut (
    .Clock(Clock), .ResetN(ResetN),
    .Branch(Branch), .BranchTarget(BranchTarget),
    .Jump(Jump), .JumpTarget(JumpTarget),
    .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemGnt(IMemGnt),
    .IMemRvalid(IMemRvalid), .IMemRdata(IMemRdata),
    .InstrValid(InstrValid), .InstrReady(InstrReady),
    .Instr(Instr), .InstrPC(InstrPC), .PCOverflow(PCOverflow)
  );

  pc_fetch_unit #(.RESET_PC(16'hFFFC), .PC_STEP(16'd2)) dut_wrap (
    .Clock(Clock), .ResetN(b_rstn),
    .Branch(1'b0), .BranchTarget(16'h0000),
    .Jump(1'b0), .JumpTarget(16'h0000),
    .IMemReq(b_req), .IMemAddr(b_addr), .IMemGnt(1'b1),
    .IMemRvalid(b_rvalid), .IMemRdata(b_rdata),
    .InstrValid(b_valid), .InstrReady(1'b1),
    .Instr(b_instr), .InstrPC(b_instr_pc), .PCOverflow(b_ovf)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    ResetN = 1'b0; Branch = 1'b0; Jump = 1'b0;
    BranchTarget = 16'h0000; JumpTarget = 16'h0000;
    IMemGnt = 1'b0; IMemRvalid = 1'b0; IMemRdata = 16'h0000; InstrReady = 1'b0;
    b_rstn = 1'b0; b_rvalid = 1'b0; b_rdata = 16'hABCD;
    tick; tick;

    chk("rst_req", {15'd0, IMemReq}, 16'd0);
    chk("rst_addr", IMemAddr, 16'h0000);
    chk("rst_valid", {15'd0, InstrValid}, 16'd0);
    chk("rst_instr", Instr, 16'h0000);
    chk("rst_instr_pc", InstrPC, 16'h0000);
    chk("rst_ovf", {15'd0, PCOverflow}, 16'd0);

    // Streaming fetch: grant immediately, response one cycle later
    ResetN = 1'b1; IMemGnt = 1'b1; InstrReady = 1'b1;
    tick;
    chk("s1_req_a", {15'd0, IMemReq}, 16'd1);
    chk("s1_addr_a", IMemAddr, 16'h0000);
    tick;
    chk("s1_req_wait_a", {15'd0, IMemReq}, 16'd0);
    IMemRvalid = 1'b1; IMemRdata = 16'h1111;
    tick;
    chk("s1_valid_a", {15'd0, InstrValid}, 16'd1);
    chk("s1_instr_a", Instr, 16'h1111);
    chk("s1_pc_a", InstrPC, 16'h0000);
    chk("s1_addr_b", IMemAddr, 16'h0002);
    IMemRvalid = 1'b0;
    tick;
    chk("s1_valid_drop", {15'd0, InstrValid}, 16'd0);
    chk("s1_req_wait_b", {15'd0, IMemReq}, 16'd0);
    IMemRvalid = 1'b1; IMemRdata = 16'h2222;
    tick;
    chk("s1_instr_b", Instr, 16'h2222);
    chk("s1_pc_b", InstrPC, 16'h0002);
    chk("s1_addr_c", IMemAddr, 16'h0004);
    IMemRvalid = 1'b0;

    // Back-pressure: second word lands in the skid
    InstrReady = 1'b0;
    tick;
    chk("s2_valid_held", {15'd0, InstrValid}, 16'd1);
    chk("s2_instr_held", Instr, 16'h2222);
    IMemRvalid = 1'b1; IMemRdata = 16'h3333;
    tick;
    chk("s2_hold_req", {15'd0, IMemReq}, 16'd0);
    chk("s2_hold_instr", Instr, 16'h2222);
    chk("s2_hold_pc", InstrPC, 16'h0002);
    IMemRvalid = 1'b0;
    tick;
    chk("s2_hold_req2", {15'd0, IMemReq}, 16'd0);
    chk("s2_hold_instr2", Instr, 16'h2222);
    InstrReady = 1'b1;
    tick;
    chk("s2_skid_instr", Instr, 16'h3333);
    chk("s2_skid_pc", InstrPC, 16'h0004);
    chk("s2_skid_valid", {15'd0, InstrValid}, 16'd1);
    chk("s2_addr_next", IMemAddr, 16'h0006);
    tick;
    chk("s2_no_dup", {15'd0, InstrValid}, 16'd0);

    // Branch while in WAIT: in-flight response discarded
    Branch = 1'b1; BranchTarget = 16'h0100;
    tick;
    Branch = 1'b0;
    chk("s3_req_wait", {15'd0, IMemReq}, 16'd0);
    IMemRvalid = 1'b1; IMemRdata = 16'h4444;
    tick;
    chk("s3_stale_dropped", {15'd0, InstrValid}, 16'd0);
    chk("s3_req_fetch", {15'd0, IMemReq}, 16'd1);
    chk("s3_addr_target", IMemAddr, 16'h0100);
    IMemRvalid = 1'b0;
    tick;
    chk("s3_valid_wait1", {15'd0, InstrValid}, 16'd0);
    tick;
    chk("s3_valid_wait2", {15'd0, InstrValid}, 16'd0);
    IMemRvalid = 1'b1; IMemRdata = 16'h5555;
    tick;
    chk("s3_instr", Instr, 16'h5555);
    chk("s3_pc", InstrPC, 16'h0100);
    chk("s3_addr_next", IMemAddr, 16'h0102);
    IMemRvalid = 1'b0;

    // Jump beats Branch; granted fetch in the same cycle is discarded
    Jump = 1'b1; JumpTarget = 16'h0200; Branch = 1'b1; BranchTarget = 16'h0300;
    tick;
    Jump = 1'b0; Branch = 1'b0;
    chk("s4_valid_cleared", {15'd0, InstrValid}, 16'd0);
    chk("s4_req_wait", {15'd0, IMemReq}, 16'd0);
    IMemRvalid = 1'b1; IMemRdata = 16'h6666;
    tick;
    chk("s4_addr_jump", IMemAddr, 16'h0200);
    chk("s4_stale_dropped", {15'd0, InstrValid}, 16'd0);
    IMemRvalid = 1'b0; IMemGnt = 1'b0;
    Jump = 1'b1; JumpTarget = 16'h0201;
    tick;
    Jump = 1'b0;
    chk("s4_addr_odd_target", IMemAddr, 16'h0200);
    chk("s4_req_nogrant", {15'd0, IMemReq}, 16'd1);
    tick;
    chk("s4_addr_stable", IMemAddr, 16'h0200);
    IMemGnt = 1'b1;
    tick;
    chk("s4_req_wait2", {15'd0, IMemReq}, 16'd0);
    IMemRvalid = 1'b1; IMemRdata = 16'h7777;
    tick;
    chk("s4_instr", Instr, 16'h7777);
    chk("s4_pc", InstrPC, 16'h0200);
    chk("s4_addr_next", IMemAddr, 16'h0202);
    IMemRvalid = 1'b0; InstrReady = 1'b0;

    // Asynchronous reset in the middle of WAIT
    tick;
    chk("s6_valid_before", {15'd0, InstrValid}, 16'd1);
    #3 ResetN = 1'b0;
    #1;
    chk("s6_async_valid", {15'd0, InstrValid}, 16'd0);
    chk("s6_async_instr", Instr, 16'h0000);
    chk("s6_async_pc", InstrPC, 16'h0000);
    chk("s6_async_req", {15'd0, IMemReq}, 16'd0);
    chk("s6_async_addr", IMemAddr, 16'h0000);
    tick;
    ResetN = 1'b1; IMemRvalid = 1'b1; IMemRdata = 16'h8888; InstrReady = 1'b1;
    tick;
    chk("s6_first_addr", IMemAddr, 16'h0000);
    chk("s6_first_req", {15'd0, IMemReq}, 16'd1);
    chk("s6_late_ignored", {15'd0, InstrValid}, 16'd0);
    IMemRvalid = 1'b0;
    tick;
    chk("s6_late_ignored2", {15'd0, InstrValid}, 16'd0);

    // PC wrap from 0xFFFC on the second instance
    b_rstn = 1'b1;
    tick;
    chk("s5_addr_fffc", b_addr, 16'hFFFC);
    chk("s5_req", {15'd0, b_req}, 16'd1);
    chk("s5_ovf0", {15'd0, b_ovf}, 16'd0);
    tick;
    b_rvalid = 1'b1;
    tick;
    chk("s5_addr_fffe", b_addr, 16'hFFFE);
    chk("s5_instr_pc", b_instr_pc, 16'hFFFC);
    chk("s5_instr", b_instr, 16'hABCD);
    chk("s5_ovf_still0", {15'd0, b_ovf}, 16'd0);
    b_rvalid = 1'b0;
    tick;
    chk("s5_ovf_set", {15'd0, b_ovf}, 16'd1);
    b_rvalid = 1'b1;
    tick;
    chk("s5_addr_wrap", b_addr, 16'h0000);
    chk("s5_instr_pc2", b_instr_pc, 16'hFFFE);
    chk("s5_ovf_sticky", {15'd0, b_ovf}, 16'd1);
    b_rvalid = 1'b0;
    tick;
    chk("s5_ovf_sticky2", {15'd0, b_ovf}, 16'd1);
    chk("s5_valid_single", {15'd0, b_valid}, 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
